// File: rtl/rv64_instruction_encoder.sv
// rv64_instruction_encoder
//   Turns field-level instruction requests into 32-bit RV64IM instruction words. This is the
//   inverse of the pipeline decoder. Each request produces one registered output word, or two
//   when an LI pseudo-op expands to LUI + ADDIW. Illegal immediates produce a single zero word
//   with out_error set.
//
//   Build option: define ENCODER_LI_EXPAND_EN to enable LI expansion (the FIRST state and the
//   ADDIW holding register). Without it, in_kind=7 produces the error word.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake
//   in_kind             : 0=R 1=I 2=S 3=B 4=U 5=J 6=I-shift 7=LI
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm : request fields
//   out_valid/out_ready : output handshake
//   out_instruction     : encoded word (0 on error)
//   out_last            : final word of the request
//   out_error           : request was illegal
module rv64_instruction_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        out_last,
  output logic        out_error
);

  localparam logic [2:0] KindR     = 3'd0;
  localparam logic [2:0] KindI     = 3'd1;
  localparam logic [2:0] KindS     = 3'd2;
  localparam logic [2:0] KindB     = 3'd3;
  localparam logic [2:0] KindU     = 3'd4;
  localparam logic [2:0] KindJ     = 3'd5;
  localparam logic [2:0] KindShift = 3'd6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOne   = 2'd1
`ifdef ENCODER_LI_EXPAND_EN
    ,
    StFirst = 2'd2
`endif
  } state_e;

  state_e      r_state;
  logic [31:0] r_instr;
  logic        r_last;
  logic        r_error;

  logic [31:0] w_word;
  logic        w_err;
  logic        w_accept;
  logic        w_hs;

  // Immediate range checks: a value fits an N-bit signed field when bits [63:N-1] all match.
  logic w_fit12, w_fit13, w_fit21, w_fit32;
  assign w_fit12 = (in_imm[63:11] == '0) || (in_imm[63:11] == '1);
  assign w_fit13 = (in_imm[63:12] == '0) || (in_imm[63:12] == '1);
  assign w_fit21 = (in_imm[63:20] == '0) || (in_imm[63:20] == '1);
  assign w_fit32 = (in_imm[63:31] == '0) || (in_imm[63:31] == '1);

`ifdef ENCODER_LI_EXPAND_EN
  logic [31:0] r_pending;
  logic [31:0] w_second;
  logic        w_two;
  logic [19:0] w_hi20;
  logic [11:0] w_lo12;
  // (imm + 0x800) >> 12 equals imm[31:12] plus a carry out of the low 12 bits, which occurs
  // exactly when imm[11] is set; 20-bit wrap matches the 32-bit wrap.
  assign w_hi20 = in_imm[31:12] + {19'd0, in_imm[11]};
  assign w_lo12 = in_imm[11:0];
`endif

  always_comb begin
    w_word = '0;
    w_err  = 1'b0;
`ifdef ENCODER_LI_EXPAND_EN
    w_two    = 1'b0;
    w_second = '0;
`endif
    unique case (in_kind)
      KindR: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      KindI: begin
        w_err  = !w_fit12;
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      KindS: begin
        w_err  = !w_fit12;
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      KindB: begin
        w_err  = !w_fit13 || in_imm[0];
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11],
                  in_opcode};
      end
      KindU: begin
        w_err  = !w_fit32 || (in_imm[11:0] != 12'd0);
        w_word = {in_imm[31:12], in_rd, in_opcode};
      end
      KindJ: begin
        w_err  = !w_fit21 || in_imm[0];
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      KindShift: begin
        w_err  = (in_imm[63:6] != '0);
        w_word = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
`ifdef ENCODER_LI_EXPAND_EN
        w_err = !w_fit32;
        if (w_hi20 == 20'd0) begin
          w_word = {w_lo12, 5'd0, 3'b000, in_rd, 7'h13};
        end else if (w_lo12 == 12'd0) begin
          w_word = {w_hi20, in_rd, 7'h37};
        end else begin
          w_word   = {w_hi20, in_rd, 7'h37};
          w_second = {w_lo12, in_rd, 3'b000, in_rd, 7'h1B};
          w_two    = !w_err;
        end
`else
        w_err = 1'b1;
`endif
      end
    endcase
    if (w_err) begin
      w_word = '0;
    end
  end

  assign out_valid       = (r_state != StIdle);
  assign w_hs            = out_valid && out_ready;
  assign in_ready        = (r_state == StIdle) || (w_hs && (r_state == StOne));
  assign w_accept        = in_valid && in_ready;
  assign out_instruction = r_instr;
  assign out_last        = r_last;
  assign out_error       = r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_instr   <= '0;
      r_last    <= 1'b0;
      r_error   <= 1'b0;
`ifdef ENCODER_LI_EXPAND_EN
      r_pending <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StOne: begin
          if (w_accept) begin
            r_instr <= w_word;
            r_error <= w_err;
`ifdef ENCODER_LI_EXPAND_EN
            r_pending <= w_second;
            r_last    <= !w_two;
            r_state   <= w_two ? StFirst : StOne;
`else
            r_last  <= 1'b1;
            r_state <= StOne;
`endif
          end else if (w_hs) begin
            r_state <= StIdle;
          end
        end
`ifdef ENCODER_LI_EXPAND_EN
        StFirst: begin
          if (w_hs) begin
            r_instr <= r_pending;
            r_last  <= 1'b1;
            r_state <= StOne;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64_instruction_encoder.sv
module tb_rv64_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic        out_last;
  logic        out_error;

  int n_vec = 0;
  int n_err = 0;

  // {valid, last, error, instruction}
  logic [34:0] obs;
  assign obs = {out_valid, out_last, out_error, out_instruction};

  typedef struct packed {
    logic [2:0]  kind;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [34:0] exp;
  } vec_t;

  rv64_instruction_encoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_opcode       (in_opcode),
    .in_funct3       (in_funct3),
    .in_funct7       (in_funct7),
    .in_rd           (in_rd),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_imm          (in_imm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_last        (out_last),
    .out_error       (out_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Presents a request from a negedge and returns 1 time unit after the accepting posedge.
  task automatic issue(input logic [2:0] kind, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] imm);
    int waited = 0;
    @(negedge clk);
    in_kind = kind; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout got in_ready=%b exp=1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_imm   = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic test_reset;
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 35'd0}) begin
      n_err++;
      $display("FAIL reset_values got=%h exp=%h", {in_ready, obs}, {1'b1, 35'd0});
    end
  endtask

  task automatic test_formats;
    vec_t t [9];
    out_ready = 1'b1;
    t[0] = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 64'd0, {3'b110, 32'h002081B3}};
    t[1] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -64'sd4, {3'b110, 32'hFE208EE3}};
    t[2] = '{3'd2, 7'h23, 3'd3, 7'h00, 5'd0, 5'd1, 5'd2, 64'd8, {3'b110, 32'h0020B423}};
    t[3] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h12345000, {3'b110, 32'h123452B7}};
    t[4] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'd2048, {3'b110, 32'h001000EF}};
    t[5] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'hFFFFE, {3'b110, 32'h7FFFF06F}};
    t[6] = '{3'd6, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 64'd63, {3'b110, 32'h43F15093}};
    t[7] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -64'sd2048, {3'b110, 32'h80000093}};
    t[8] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'd4094, {3'b110, 32'h7E000FE3}};
    for (int i = 0; i < 9; i++) begin
      issue(t[i].kind, t[i].opc, t[i].f3, t[i].f7, t[i].rd, t[i].rs1, t[i].rs2, t[i].imm);
      n_vec++;
      if (obs !== t[i].exp) begin
        n_err++;
        $display("FAIL format[%0d] got=%h exp=%h", i, obs, t[i].exp);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL format_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_imm_errors;
    vec_t t [10];
    out_ready = 1'b1;
    t[0] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'd2048, {3'b111, 32'd0}};
    t[1] = '{3'd2, 7'h23, 3'd3, 7'h00, 5'd0, 5'd1, 5'd2, -64'sd2049, {3'b111, 32'd0}};
    t[2] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 64'd3, {3'b111, 32'd0}};
    t[3] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 64'd4096, {3'b111, 32'd0}};
    t[4] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'd5, {3'b111, 32'd0}};
    t[5] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'h100000, {3'b111, 32'd0}};
    t[6] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h12345001, {3'b111, 32'd0}};
    t[7] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h80000000, {3'b111, 32'd0}};
    t[8] = '{3'd6, 7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 64'd64, {3'b111, 32'd0}};
    t[9] = '{3'd6, 7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, -64'sd1, {3'b111, 32'd0}};
    for (int i = 0; i < 10; i++) begin
      issue(t[i].kind, t[i].opc, t[i].f3, t[i].f7, t[i].rd, t[i].rs1, t[i].rs2, t[i].imm);
      n_vec++;
      if (obs !== t[i].exp) begin
        n_err++;
        $display("FAIL imm_error[%0d] got=%h exp=%h", i, obs, t[i].exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_li_two;
    logic [34:0] e;
    out_ready = 1'b1;
    issue(3'd7, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h12345678);
`ifdef ENCODER_LI_EXPAND_EN
    e = {3'b100, 32'h123452B7};
`else
    e = {3'b111, 32'd0};
`endif
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL li_a_w0 got=%h exp=%h", obs, e); end
`ifdef ENCODER_LI_EXPAND_EN
    @(posedge clk); #1;
    e = {3'b110, 32'h6782829B};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL li_a_w1 got=%h exp=%h", obs, e); end
`endif
    @(posedge clk); #1;
    issue(3'd7, 7'h00, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 64'h7FFFF800);
`ifdef ENCODER_LI_EXPAND_EN
    e = {3'b100, 32'h800000B7};
`else
    e = {3'b111, 32'd0};
`endif
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL li_b_w0 got=%h exp=%h", obs, e); end
`ifdef ENCODER_LI_EXPAND_EN
    @(posedge clk); #1;
    e = {3'b110, 32'h8000809B};
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL li_b_w1 got=%h exp=%h", obs, e); end
`endif
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL li_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_li_single;
    logic [63:0] imm  [4];
    logic [4:0]  rd   [4];
    logic [34:0] e    [4];
    imm[0] = 64'd5;        rd[0] = 5'd2;
    imm[1] = -64'sd1;      rd[1] = 5'd5;
    imm[2] = 64'h1000;     rd[2] = 5'd3;
    imm[3] = 64'h80000000; rd[3] = 5'd4;
`ifdef ENCODER_LI_EXPAND_EN
    e[0] = {3'b110, 32'h00500113};
    e[1] = {3'b110, 32'hFFF00293};
    e[2] = {3'b110, 32'h000011B7};
`else
    e[0] = {3'b111, 32'd0};
    e[1] = {3'b111, 32'd0};
    e[2] = {3'b111, 32'd0};
`endif
    e[3] = {3'b111, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(3'd7, 7'h00, 3'd0, 7'h00, rd[i], 5'd0, 5'd0, imm[i]);
      n_vec++;
      if (obs !== e[i]) begin n_err++; $display("FAIL li_single[%0d] got=%h exp=%h", i, obs, e[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_li_stall;
    logic [34:0] e;
    out_ready = 1'b0;
    issue(3'd7, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h12345678);
`ifdef ENCODER_LI_EXPAND_EN
    e = {3'b100, 32'h123452B7};
`else
    e = {3'b111, 32'd0};
`endif
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL stall_w0[%0d] got=%h exp=%h", c, obs, e); end
      if (c < 3) begin @(posedge clk); #1; end
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_in_ready got=%b exp=0", in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
`ifdef ENCODER_LI_EXPAND_EN
    out_ready = 1'b0;
    e = {3'b110, 32'h6782829B};
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL stall_w1[%0d] got=%h exp=%h", c, obs, e); end
      if (c < 3) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
`endif
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [34:0] e;
    out_ready = 1'b1;
    issue(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 64'd0);
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 3'b110, 32'h002081B3}) begin
      n_err++;
      $display("FAIL b2b_add got=%h exp=%h", {in_ready, obs}, {1'b1, 3'b110, 32'h002081B3});
    end
    issue(3'd7, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h12345678);
`ifdef ENCODER_LI_EXPAND_EN
    e = {3'b100, 32'h123452B7};
    n_vec++;
    if ({in_ready, obs} !== {1'b0, e}) begin
      n_err++;
      $display("FAIL b2b_lui got=%h exp=%h", {in_ready, obs}, {1'b0, e});
    end
    @(posedge clk); #1;
    e = {3'b110, 32'h6782829B};
`else
    e = {3'b111, 32'd0};
`endif
    n_vec++;
    if ({in_ready, obs} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL b2b_last got=%h exp=%h", {in_ready, obs}, {1'b1, e});
    end
    issue(3'd1, 7'h13, 3'd0, 7'h00, 5'd7, 5'd7, 5'd0, 64'd1);
    n_vec++;
    if (obs !== {3'b110, 32'h00138393}) begin
      n_err++;
      $display("FAIL b2b_addi got=%h exp=%h", obs, {3'b110, 32'h00138393});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_li;
    logic [34:0] e;
    out_ready = 1'b0;
    issue(3'd7, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 64'h12345678);
`ifdef ENCODER_LI_EXPAND_EN
    e = {3'b100, 32'h123452B7};
`else
    e = {3'b111, 32'd0};
`endif
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL rst_held got=%h exp=%h", obs, e); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, obs} !== {1'b1, 35'd0}) begin
      n_err++;
      $display("FAIL rst_async got=%h exp=%h", {in_ready, obs}, {1'b1, 35'd0});
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    issue(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 64'd0);
    n_vec++;
    if (obs !== {3'b110, 32'h002081B3}) begin
      n_err++;
      $display("FAIL rst_add got=%h exp=%h", obs, {3'b110, 32'h002081B3});
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_addiw got out_valid=%b exp=0", out_valid);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_kind = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_formats();
    test_imm_errors();
    test_li_two();
    test_li_single();
    test_li_stall();
    test_back_to_back();
    test_reset_mid_li();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
